// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: state encoding and counter sizing shared by the serial adder files
package serial_adder_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
  function automatic int clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/serial_adder_digit_add.sv
// digit_add: one DIGIT-bit adder slice with carry out and carry into the top bit
module digit_add #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);
  logic [DIGIT:0] full;
  assign full  = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
  assign sum   = full[DIGIT-1:0];
  assign cout  = full[DIGIT];
  assign c_msb = sum[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];
endmodule

// File: rtl/serial_adder.sv
// serial_adder: digit-serial add/subtract with valid/ready operand and result handshakes
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   s,
  output logic             ovf
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = clog2(N);
  state_t           state, next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] ra, rb;
  logic             carry, last, cout, c_msb;
  logic [DIGIT-1:0] sd;
  assign last      = cnt == CW'(N - 1);
  assign in_ready  = state == S_IDLE && !rst;
  assign out_valid = state == S_DONE;
  digit_add #(.DIGIT(DIGIT)) u_digit (
    .x(ra[cnt*DIGIT +: DIGIT]),
    .y(rb[cnt*DIGIT +: DIGIT]),
    .cin(carry),
    .sum(sd),
    .cout(cout),
    .c_msb(c_msb)
  );
  always_comb begin
    next = state;
    if (state == S_IDLE && in_valid) next = S_RUN;
    else if (state == S_RUN && last) next = S_DONE;
    else if (state == S_DONE && out_ready) next = S_IDLE;
  end
  // subtraction is a + ~b + 1: invert B once at accept and seed the carry with sub
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      s     <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= next;
      if (state == S_IDLE && in_valid) begin
        ra    <= a;
        rb    <= sub ? ~b : b;
        carry <= sub;
        cnt   <= '0;
      end else if (state == S_RUN) begin
        s[cnt*DIGIT +: DIGIT] <= sd;
        carry <= cout;
        cnt   <= last ? '0 : cnt + 1'b1;
        if (last) begin
          s[WIDTH] <= cout;
          ovf      <= c_msb ^ cout;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors on three parameterisations against an arithmetic model
module tb_serial_adder;
  logic        clk = 1'b0;
  logic        rst, in_valid, sub, out_ready;
  logic [15:0] a, b;
  logic        ov[3], ir[3], of[3];
  logic [16:0] s0, s1, sv[3];
  logic [8:0]  s2;
  int checks = 0, errors = 0;
  bit started = 0;
  bit pend[3];
  int age[3];
  longint es[3], ls[3];
  bit eo[3], lo[3];
  int lat_m[3] = '{4, 1, 4};
  int wd[3] = '{16, 16, 8};

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(16), .DIGIT(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b), .sub(sub),
    .out_valid(ov[0]), .out_ready(out_ready), .s(s0), .ovf(of[0]));
  serial_adder #(.WIDTH(16), .DIGIT(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b), .sub(sub),
    .out_valid(ov[1]), .out_ready(out_ready), .s(s1), .ovf(of[1]));
  serial_adder #(.WIDTH(8), .DIGIT(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .a(a[7:0]), .b(b[7:0]), .sub(sub),
    .out_valid(ov[2]), .out_ready(out_ready), .s(s2), .ovf(of[2]));

  assign sv[0] = s0;
  assign sv[1] = s1;
  assign sv[2] = {8'b0, s2};

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // Result from plain integer arithmetic: signed range test for ovf, compare/overflow for carry.
  task automatic model(input int w, input longint x, input longint y, input bit sb,
                       output longint rs, output bit ro);
    longint m = longint'(1) << w;
    longint xa = x & (m - 1), ya = y & (m - 1);
    longint sx = (xa >= m / 2) ? xa - m : xa;
    longint sy = (ya >= m / 2) ? ya - m : ya;
    longint r = sb ? sx - sy : sx + sy;
    longint low = (((sb ? xa - ya : xa + ya) % m) + m) % m;
    bit c = sb ? (xa >= ya) : (xa + ya >= m);
    rs = low + (c ? m : 0);
    ro = (r < -(m / 2)) || (r >= m / 2);
  endtask

  always @(posedge clk)
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        pend[i] = 0; ls[i] = 0; lo[i] = 0;
      end else if (pend[i]) begin
        if (age[i] >= lat_m[i] && out_ready) pend[i] = 0;
        else if (age[i] < lat_m[i]) begin
          age[i]++;
          if (age[i] == lat_m[i]) begin ls[i] = es[i]; lo[i] = eo[i]; end
        end
      end else if (in_valid) begin
        pend[i] = 1; age[i] = 0;
        model(wd[i], longint'(a), longint'(b), sub, es[i], eo[i]);
      end
    end

  always @(negedge clk)
    if (started)
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("out_valid%0d", i), 32'(ov[i]), 32'(pend[i] && age[i] >= lat_m[i]));
        chk($sformatf("in_ready%0d", i), 32'(ir[i]), 32'(!pend[i] && !rst));
        if (!pend[i] || age[i] >= lat_m[i]) begin
          chk($sformatf("s%0d", i), 32'(sv[i]), 32'(ls[i]));
          chk($sformatf("ovf%0d", i), 32'(of[i]), 32'(lo[i]));
        end
      end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic op(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                    input logic [16:0] xs, input logic xo);
    int lat = 0;
    a = ta; b = tb; sub = ts; in_valid = 1;
    tick;
    in_valid = 0; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
    while (!ov[0] && lat < 20) begin tick; lat++; end
    chk("latency", 32'(lat), 32'd4);
    chk("op_s", 32'(s0), 32'(xs));
    chk("op_ovf", 32'(of[0]), 32'(xo));
    out_ready = 1;
    tick;
    out_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; in_valid = 0; a = '0; b = '0; sub = 0; out_ready = 0;
    tick;
    started = 1;
    tick; tick;
    rst = 0;
    #1;
    chk("ready_after_rst", 32'(ir[0]), 32'd1);
    chk("rst_s", 32'(s0), 32'd0);
    op(16'hFFFF, 16'h0001, 0, 17'h10000, 0);
    chk("n1_s", 32'(s1), 32'h10000);
    chk("w8_s", 32'(s2), 32'h100);
    op(16'h7FFF, 16'h0001, 0, 17'h08000, 1);
    op(16'h0005, 16'h0007, 1, 17'h0FFFE, 0);
    op(16'h8000, 16'h0001, 1, 17'h17FFF, 1);
    op(16'h1234, 16'h1234, 1, 17'h10000, 0);
    // hold the result under backpressure while new operands are offered
    a = 16'h1234; b = 16'h0F0F; sub = 0; in_valid = 1;
    tick;
    a = 16'hAAAA; b = 16'h5555; sub = 1;
    repeat (4) tick;
    chk("bp_valid", 32'(ov[0]), 32'd1);
    for (int k = 0; k < 10; k++) begin
      tick;
      chk("bp_hold_s", 32'(s0), 32'h02143);
      chk("bp_ready", 32'(ir[0]), 32'd0);
    end
    out_ready = 1;
    tick;
    out_ready = 0; in_valid = 0;
    chk("bp_idle", 32'(ir[0]), 32'd1);
    op(16'h1000, 16'h0001, 1, 17'h10FFF, 0);
    // abort: reset lands on the second RUN edge
    a = 16'h00FF; b = 16'h0101; sub = 0; in_valid = 1;
    tick;
    in_valid = 0;
    tick;
    rst = 1;
    tick;
    rst = 0;
    #1;
    chk("abort_ready", 32'(ir[0]), 32'd1);
    chk("abort_s", 32'(s0), 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick;
      chk("abort_no_valid", 32'(ov[0]), 32'd0);
    end
    op(16'h00FF, 16'h0101, 0, 17'h00200, 0);
    repeat (3) tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
